// File: rtl/wb_pkg.sv
// Shared types and constants for the GRF writeback port.
// Both writeback sources and the long-latency FIFO entries use wb_req_t.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_req_t;

endpackage

// File: rtl/wb_write_port_if.sv
// Bus bundle for wb_write_port.
// The master side is the pipeline/MDU; the slave side is the write port.
interface wb_write_port_if #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    logic                          issue_valid;
    logic [wb_pkg::REG_W-1:0]      issue_rd;

    logic                          pipe_wb_valid;
    logic [wb_pkg::REG_W-1:0]      pipe_wb_rd;
    logic [DATA_W-1:0]             pipe_wb_data;
    logic [DATA_W-1:0]             pipe_wb_pc;

    logic                          lat_wb_valid;
    logic                          lat_wb_ready;
    logic [wb_pkg::REG_W-1:0]      lat_wb_rd;
    logic [DATA_W-1:0]             lat_wb_data;
    logic [DATA_W-1:0]             lat_wb_pc;

    logic                          grf_we;
    logic [wb_pkg::REG_W-1:0]      grf_a3;
    logic [DATA_W-1:0]             grf_wd;
    logic [DATA_W-1:0]             grf_pc;

    logic [31:0]                   pending;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output issue_valid, issue_rd,
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data, pipe_wb_pc,
        output lat_wb_valid, lat_wb_rd, lat_wb_data, lat_wb_pc,
        input  lat_wb_ready,
        input  grf_we, grf_a3, grf_wd, grf_pc,
        input  pending, fifo_count
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data, pipe_wb_pc,
        input  lat_wb_valid, lat_wb_rd, lat_wb_data, lat_wb_pc,
        output lat_wb_ready,
        output grf_we, grf_a3, grf_wd, grf_pc,
        output pending, fifo_count
    );

endinterface

// File: rtl/wb_req_fifo.sv
// Synchronous FIFO of wb_req_t. The caller guarantees that push is only
// raised when !full and pop only when !empty; DEPTH must be a power of two.
module wb_req_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  wb_pkg::wb_req_t         push_data,
    input  logic                    pop,
    output wb_pkg::wb_req_t         pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    import wb_pkg::*;

    localparam int AW = $clog2(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_port.sv
// GRF write-port arbiter: W-stage results win, long-latency results drain
// from a FIFO, plus the pending-write scoreboard. Define WB_TRACE_EN for trace.
module wb_write_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = wb_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    wb_write_port_if.slave   wb
);
    import wb_pkg::*;

    wb_req_t                       lat_req;
    wb_req_t                       pipe_req;
    wb_req_t                       head;
    wb_req_t                       sel_req;
    logic                          sel_valid;
    logic                          full;
    logic                          empty;
    logic                          push;
    logic                          pop;
    logic [$clog2(FIFO_DEPTH):0]   count;

    logic                          grf_we_q;
    logic [REG_W-1:0]              grf_a3_q;
    logic [DATA_W-1:0]             grf_wd_q;
    logic [DATA_W-1:0]             grf_pc_q;
    logic [31:0]                   pending_q;
    logic [31:0]                   set_mask;
    logic [31:0]                   clear_mask;

    assign lat_req  = '{rd: wb.lat_wb_rd,  data: wb.lat_wb_data,  pc: wb.lat_wb_pc};
    assign pipe_req = '{rd: wb.pipe_wb_rd, data: wb.pipe_wb_data, pc: wb.pipe_wb_pc};

    // Ready looks only at the registered count: a full FIFO refuses even
    // when it is being popped in the same cycle.
    assign push = wb.lat_wb_valid && !full;
    assign pop  = !wb.pipe_wb_valid && !empty;

    wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (lat_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        sel_valid = wb.pipe_wb_valid || !empty;
        sel_req   = wb.pipe_wb_valid ? pipe_req : head;
    end

    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (wb.issue_valid && wb.issue_rd != REG_ZERO)
            set_mask[wb.issue_rd] = 1'b1;
        if (grf_we_q)
            clear_mask[grf_a3_q] = 1'b1;
    end

    // A $0 request still occupies the output stage but never asserts RegWrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we_q  <= 1'b0;
            grf_a3_q  <= '0;
            grf_wd_q  <= '0;
            grf_pc_q  <= '0;
            pending_q <= '0;
        end else begin
            grf_we_q <= sel_valid && (sel_req.rd != REG_ZERO);
            if (sel_valid) begin
                grf_a3_q <= sel_req.rd;
                grf_wd_q <= sel_req.data;
                grf_pc_q <= sel_req.pc;
            end
            pending_q <= (pending_q & ~clear_mask) | set_mask;
        end
    end

    assign wb.lat_wb_ready = !full;
    assign wb.fifo_count   = count;
    assign wb.grf_we       = grf_we_q;
    assign wb.grf_a3       = grf_a3_q;
    assign wb.grf_wd       = grf_wd_q;
    assign wb.grf_pc       = grf_pc_q;
    // D-stage sees the retiring register as free; GRF forwarding covers it.
    assign wb.pending      = pending_q & ~clear_mask;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (grf_we_q && grf_a3_q != REG_ZERO)
            $display("%d@%h: $%d <= %h", $time, grf_pc_q, grf_a3_q, grf_wd_q);
    end
`else
    // Trace off: the GRF prints its own writeback line in this build.
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Randomised + directed bench for wb_write_port against a queue-based model.
module tb_wb_write_port;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   started;

    wb_write_port_if #(.DATA_W(32), .FIFO_DEPTH(DEPTH)) bus ();

    wb_write_port #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue for the FIFO, plain variables for the output stage.
    wb_req_t     mq[$];
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic [31:0] m_pend;

    always @(posedge clk) begin
        wb_req_t     r;
        bit          have;
        bit          was_full;
        logic [31:0] clr;
        if (reset) begin
            mq.delete();
            m_we = 0; m_a3 = '0; m_wd = '0; m_pc = '0; m_pend = '0;
            started = 1;
        end else begin
            clr      = m_we ? (32'd1 << m_a3) : 32'd0;
            was_full = (mq.size() >= DEPTH);
            have     = 0;
            r        = '0;
            if (bus.pipe_wb_valid) begin
                r = '{rd: bus.pipe_wb_rd, data: bus.pipe_wb_data, pc: bus.pipe_wb_pc};
                have = 1;
            end else if (mq.size() > 0) begin
                r = mq.pop_front();
                have = 1;
            end
            if (bus.lat_wb_valid && !was_full)
                mq.push_back('{rd: bus.lat_wb_rd, data: bus.lat_wb_data, pc: bus.lat_wb_pc});
            m_we = have && (r.rd != 5'd0);
            if (have) begin
                m_a3 = r.rd; m_wd = r.data; m_pc = r.pc;
            end
            m_pend = (m_pend & ~clr);
            if (bus.issue_valid && bus.issue_rd != 5'd0)
                m_pend[bus.issue_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_pend;
        if (started) begin
            exp_pend = m_pend & ~(m_we ? (32'd1 << m_a3) : 32'd0);
            chk("m_grf_we",  64'(bus.grf_we), 64'(m_we));
            chk("m_grf_a3",  64'(bus.grf_a3), 64'(m_a3));
            chk("m_grf_wd",  64'(bus.grf_wd), 64'(m_wd));
            chk("m_grf_pc",  64'(bus.grf_pc), 64'(m_pc));
            chk("m_pending", 64'(bus.pending), 64'(exp_pend));
            chk("m_count",   64'(bus.fifo_count), 64'(mq.size()));
            chk("m_ready",   64'(bus.lat_wb_ready), 64'(mq.size() < DEPTH));
        end
    end

    task automatic idle();
        bus.issue_valid   = 0; bus.issue_rd    = '0;
        bus.pipe_wb_valid = 0; bus.pipe_wb_rd  = '0; bus.pipe_wb_data = '0; bus.pipe_wb_pc = '0;
        bus.lat_wb_valid  = 0; bus.lat_wb_rd   = '0; bus.lat_wb_data  = '0; bus.lat_wb_pc  = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; started = 0;
        idle();
        reset = 1;
        step(); step();
        chk("rst_we",    64'(bus.grf_we), 64'd0);
        chk("rst_a3",    64'(bus.grf_a3), 64'd0);
        chk("rst_wd",    64'(bus.grf_wd), 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_ready", 64'(bus.lat_wb_ready), 64'd1);
        chk("rst_pend",  64'(bus.pending), 64'd0);
        reset = 0;

        // Single W-stage write.
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd5;
        bus.pipe_wb_data = 32'h1234; bus.pipe_wb_pc = 32'h3000;
        step(); idle();
        chk("t1_we", 64'(bus.grf_we), 64'd1);
        chk("t1_a3", 64'(bus.grf_a3), 64'd5);
        chk("t1_wd", 64'(bus.grf_wd), 64'h1234);
        chk("t1_pc", 64'(bus.grf_pc), 64'h3000);
        step();
        chk("t1_we_off", 64'(bus.grf_we), 64'd0);

        // Fill the FIFO under continuous W-stage traffic, then drain in order.
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd9; bus.pipe_wb_data = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            bus.lat_wb_valid = 1; bus.lat_wb_rd = 5'(i);
            bus.lat_wb_data = 32'(100 + i); bus.lat_wb_pc = 32'(32'h4000 + 4 * i);
            step();
        end
        chk("t2_count4", 64'(bus.fifo_count), 64'd4);
        chk("t2_ready0", 64'(bus.lat_wb_ready), 64'd0);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t2_drain_a3", 64'(bus.grf_a3), 64'(i));
        end
        chk("t2_count0", 64'(bus.fifo_count), 64'd0);
        chk("t2_ready1", 64'(bus.lat_wb_ready), 64'd1);

        // Full FIFO refuses a push in the cycle it pops.
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            bus.lat_wb_valid = 1; bus.lat_wb_rd = 5'(11 + i);
            bus.lat_wb_data = 32'(200 + i); bus.lat_wb_pc = 32'(32'h5000 + 4 * i);
            step();
        end
        chk("t3_full", 64'(bus.fifo_count), 64'd4);
        bus.pipe_wb_valid = 0;
        bus.lat_wb_rd = 5'd20; bus.lat_wb_data = 32'hABCD; bus.lat_wb_pc = 32'h6000;
        step();
        chk("t3_pop_cnt", 64'(bus.fifo_count), 64'd3);
        chk("t3_pop_a3",  64'(bus.grf_a3), 64'd11);
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd0;
        step();
        chk("t3_refill", 64'(bus.fifo_count), 64'd4);
        idle();
        repeat (6) step();

        // Scoreboard set / combinational clear / set-wins.
        bus.issue_valid = 1; bus.issue_rd = 5'd7;
        step(); idle();
        chk("t4_set", 64'(bus.pending[7]), 64'd1);
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd7; bus.pipe_wb_data = 32'h77;
        step(); idle();
        chk("t4_we7",  64'(bus.grf_a3), 64'd7);
        chk("t4_clr",  64'(bus.pending[7]), 64'd0);
        bus.issue_valid = 1; bus.issue_rd = 5'd7;
        step(); idle();
        chk("t4_setwins", 64'(bus.pending[7]), 64'd1);
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd7;
        step(); idle(); step();

        // $0 from both sources: consumed, never written.
        bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'h1;
        bus.lat_wb_valid = 1; bus.lat_wb_rd = 5'd0; bus.lat_wb_data = 32'h2;
        bus.issue_valid = 1; bus.issue_rd = 5'd0;
        step(); idle();
        chk("t5_we0a",  64'(bus.grf_we), 64'd0);
        chk("t5_cnt1",  64'(bus.fifo_count), 64'd1);
        step();
        chk("t5_we0b",  64'(bus.grf_we), 64'd0);
        chk("t5_cnt0",  64'(bus.fifo_count), 64'd0);
        chk("t5_pend0", 64'(bus.pending[0]), 64'd0);

        // Random traffic; the negedge compare process does the checking.
        for (int n = 0; n < 1500; n++) begin
            bus.issue_valid   = ($urandom_range(0, 3) == 0);
            bus.issue_rd      = 5'($urandom_range(0, 31));
            bus.pipe_wb_valid = ($urandom_range(0, 9) < 4);
            bus.pipe_wb_rd    = 5'($urandom_range(0, 31));
            bus.pipe_wb_data  = $urandom;
            bus.pipe_wb_pc    = $urandom;
            bus.lat_wb_valid  = ($urandom_range(0, 1) == 1);
            bus.lat_wb_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.lat_wb_data   = $urandom;
            bus.lat_wb_pc     = $urandom;
            step();
        end
        idle();

        // Mid-operation reset with count=3 and pending=0xF0.
        reset = 1; step(); reset = 0;
        for (int i = 4; i <= 7; i++) begin
            bus.issue_valid = 1; bus.issue_rd = 5'(i);
            bus.pipe_wb_valid = 1; bus.pipe_wb_rd = 5'd0;
            bus.lat_wb_valid = (i < 7); bus.lat_wb_rd = 5'(20 + i);
            bus.lat_wb_data = 32'(i); bus.lat_wb_pc = 32'(i * 4);
            step();
        end
        idle();
        chk("t6_cnt3",  64'(bus.fifo_count), 64'd3);
        chk("t6_pendF0", 64'(bus.pending), 64'h0000_00F0);
        reset = 1;
        step();
        chk("t6_cnt",   64'(bus.fifo_count), 64'd0);
        chk("t6_pend",  64'(bus.pending), 64'd0);
        chk("t6_ready", 64'(bus.lat_wb_ready), 64'd1);
        chk("t6_we",    64'(bus.grf_we), 64'd0);
        reset = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_port.md
Name: wb_write_port

Overview:
- Writer end of the GRF write port (RegWrite/A3/WD/PC_W).
- Merges two writeback sources onto the single GRF write port:
  - in-order W-stage results;
  - out-of-order long-latency results from the MDU/load side, buffered in a small FIFO.
- Maintains a per-register pending-write scoreboard that the D-stage hazard unit uses for stall decisions.

Parameters:
FIFO_DEPTH, 4, entries in the long-latency writeback FIFO (power of two, >=2)
DATA_W, 32, register data and PC width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  D-stage issues an instruction that will write issue_rd
issue_rd  in  5  destination register reserved at issue
pipe_wb_valid  in  1  W-stage writeback request (never back-pressured)
pipe_wb_rd  in  5  W-stage destination register
pipe_wb_data  in  DATA_W  W-stage write data
pipe_wb_pc  in  DATA_W  W-stage instruction PC
lat_wb_valid  in  1  long-latency source request
lat_wb_ready  out  1  FIFO can accept (= count < FIFO_DEPTH)
lat_wb_rd  in  5  long-latency destination register
lat_wb_data  in  DATA_W  long-latency write data
lat_wb_pc  in  DATA_W  long-latency PC
grf_we  out  1  GRF RegWrite
grf_a3  out  5  GRF write address
grf_wd  out  DATA_W  GRF write data
grf_pc  out  DATA_W  PC of the write, for the trace
pending  out  32  scoreboard: bit r=1 means register r has an outstanding write
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On reset, grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, pending=0, FIFO empty (count=0, pointers=0), lat_wb_ready=1. A reset mid-operation discards all FIFO contents and pending bits.
- Output stage is registered. A request selected in cycle N appears on grf_* in cycle N+1 for exactly one cycle. Otherwise grf_we=0 and grf_a3/grf_wd/grf_pc hold their last values.
- Selection each cycle:
  - pipe_wb_valid=1 has priority. pipe_wb_* is loaded into the output stage.
  - Otherwise, if FIFO is non-empty, the head is popped into the output stage.
  - Otherwise grf_we=0 next cycle.
- Long-latency handshake:
  - Push occurs when lat_wb_valid && lat_wb_ready. Data is captured in the same cycle.
  - lat_wb_ready is based on the current count only. A full FIFO does not accept, even if a pop occurs that cycle.
  - Simultaneous push and pop: count is unchanged and pointers both advance, wrapping modulo FIFO_DEPTH.
  - The FIFO is FIFO-ordered, with no bypass. A push into an empty FIFO is poppable the following cycle at the earliest.
- Register $0:
  - A selected request with rd=0 produces grf_we=0.
  - A long-latency request with rd=0 is still accepted and pushed, and consumes its slot when popped.
  - Issue with issue_rd=0 sets no bit; pending[0] is always 0.
- Scoreboard:
  - pending_q[r] is set on issue_valid && issue_rd==r (r!=0).
  - pending_q[r] is cleared in the cycle grf_we=1 && grf_a3==r.
  - If set and clear hit the same register in the same cycle, set wins.
  - Output pending = pending_q & ~clear_mask (combinational), where clear_mask is the one-hot of grf_a3 when grf_we=1. In that cycle D reads the value via GRF internal forwarding instead of stalling.
- fifo_count equals the registered occupancy. Overflow is impossible by handshake; underflow is impossible by the non-empty check.

Optional Feature:
- WB_TRACE_EN defined: on each posedge with grf_we=1 && grf_a3!=0, emit $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd). This is the team's standard writeback trace. When this block is used, the GRF's own display must be disabled so each write is traced exactly once.
- WB_TRACE_EN undefined: no simulation output. Logic is identical.

Decomposition:
- Package wb_pkg:
  - REG_ZERO (5'd0), REG_W (5), DATA_W default;
  - typedef wb_req_t {rd, data, pc} shared by both sources and the FIFO entry.
- One sub-module: wb_req_fifo. It is a parameterised synchronous FIFO of wb_req_t with push/pop/full/empty/count. Arbitration, output register and scoreboard stay in wb_write_port.

Test Plan:
- pipe_wb_valid=1, rd=5, data=0x1234, pc=0x3000 at cycle N -> grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000 at N+1 only; grf_we=0 at N+2.
- Push 4 long-latency requests (rd=1..4) while pipe_wb_valid=1 continuously:
  - lat_wb_ready=0 after the 4th push, fifo_count=4;
  - after pipe stops, grf_a3 = 1,2,3,4 on consecutive cycles, then fifo_count=0 and ready=1.
- Full FIFO with pipe idle and lat_wb_valid=1 -> no push in the pop cycle; push accepted the next cycle; count goes 4 -> 3 -> 4.
- issue_valid with rd=7 -> pending[7]=1 next cycle. Later, in the cycle grf_we=1 with a3=7, pending[7] reads 0 combinationally. If issue rd=7 arrives in that same cycle, pending[7] stays 1.
- pipe rd=0 and lat rd=0 requests -> both consumed, grf_we never asserted, pending[0]=0 throughout.
- Reset asserted with FIFO at count=3 and pending=0x000000F0 -> next cycle count=0, pending=0, lat_wb_ready=1, grf_we=0.
